// File: rtl/tmr_vote_monitor.sv
// rtl/tmr_vote_monitor.sv - majority voter with per-replica error counters and mismatch report FIFO
// Optional report FIFO, timestamp and overflow flag enabled by macro TMR_VOTE_REPORT_FIFO_EN.
module tmr_vote_monitor #(
  parameter int W          = 8,
  parameter int CNT_W      = 8,
  parameter int TS_W       = 12,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [W-1:0]      in_a,
  input  logic [W-1:0]      in_b,
  input  logic [W-1:0]      in_c,
  output logic              out_valid,
  output logic [W-1:0]      out_data,
  output logic              err_a,
  output logic              err_b,
  output logic              err_c,
  output logic [CNT_W-1:0]  cnt_a,
  output logic [CNT_W-1:0]  cnt_b,
  output logic [CNT_W-1:0]  cnt_c,
  input  logic              clr,
  output logic              rpt_valid,
  input  logic              rpt_ready,
  output logic [3+TS_W-1:0] rpt_data,
  output logic              rpt_ovf
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [W-1:0]     vote;
  logic [2:0]       mask;
  logic             out_valid_q;
  logic [W-1:0]     out_data_q;
  logic [2:0]       err_q;
  logic [CNT_W-1:0] cnt_q [3];
  logic [CNT_W-1:0] cnt_d [3];

  assign vote = (in_a & in_b) | (in_b & in_c) | (in_a & in_c);
  // mask bit 2 = a, bit 1 = b, bit 0 = c; counters are indexed the same way
  assign mask = in_valid ? {|(in_a ^ vote), |(in_b ^ vote), |(in_c ^ vote)} : 3'b000;

  always_comb begin
    for (int i = 0; i < 3; i++) begin
      cnt_d[i] = cnt_q[i];
      if (clr)
        cnt_d[i] = '0;
      else if (mask[i] && (cnt_q[i] != CNT_MAX))
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      err_q       <= 3'b000;
      for (int i = 0; i < 3; i++) cnt_q[i] <= '0;
    end else begin
      out_valid_q <= in_valid;
      if (in_valid) out_data_q <= vote;
      err_q <= mask;
      for (int i = 0; i < 3; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign err_a     = err_q[2];
  assign err_b     = err_q[1];
  assign err_c     = err_q[0];
  assign cnt_a     = cnt_q[2];
  assign cnt_b     = cnt_q[1];
  assign cnt_c     = cnt_q[0];

`ifdef TMR_VOTE_REPORT_FIFO_EN
  localparam int AW = $clog2(FIFO_DEPTH);

  logic [3+TS_W-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [AW:0]       count_q, count_d;
  logic [TS_W-1:0]   ts_q;
  logic              ovf_q;
  logic              push, pop, full, push_ok;

  // Depth is a power of two, so the count MSB alone marks full
  assign full    = count_q[AW];
  assign pop     = (count_q != '0) && rpt_ready;
  assign push    = |mask;
  assign push_ok = push && (!full || pop);
  assign count_d = count_q + (AW+1)'(push_ok) - (AW+1)'(pop);

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= {mask, ts_q};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ts_q     <= '0;
      ovf_q    <= 1'b0;
    end else begin
      ts_q    <= ts_q + TS_W'(1);
      count_q <= count_d;
      if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)     rd_ptr_q <= rd_ptr_q + AW'(1);
      if (clr)
        ovf_q <= 1'b0;
      else if (push && !push_ok)
        ovf_q <= 1'b1;
    end
  end

  assign rpt_valid = (count_q != '0);
  assign rpt_data  = rpt_valid ? mem_q[rd_ptr_q] : '0;
  assign rpt_ovf   = ovf_q;
`else
  logic unused_rpt_ready;
  assign unused_rpt_ready = rpt_ready;
  assign rpt_valid = 1'b0;
  assign rpt_data  = '0;
  assign rpt_ovf   = 1'b0;
`endif

endmodule

// File: tb/tb_tmr_vote_monitor.sv
// tb/tb_tmr_vote_monitor.sv - randomized self-checking bench for tmr_vote_monitor against a queue-based model
module tb_tmr_vote_monitor;
  localparam int W     = 8;
  localparam int CNT_W = 4;
  localparam int TS_W  = 12;
  localparam int DEPTH = 4;
  localparam int CMAX  = (1 << CNT_W) - 1;
`ifdef TMR_VOTE_REPORT_FIFO_EN
  localparam bit FIFO_EN = 1'b1;
`else
  localparam bit FIFO_EN = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst, in_valid, clr, rpt_ready;
  logic [W-1:0]      in_a, in_b, in_c;
  logic              out_valid, err_a, err_b, err_c, rpt_valid, rpt_ovf;
  logic [W-1:0]      out_data;
  logic [CNT_W-1:0]  cnt_a, cnt_b, cnt_c;
  logic [3+TS_W-1:0] rpt_data;

  tmr_vote_monitor #(.W(W), .CNT_W(CNT_W), .TS_W(TS_W), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_a(in_a), .in_b(in_b), .in_c(in_c),
    .out_valid(out_valid), .out_data(out_data), .err_a(err_a), .err_b(err_b), .err_c(err_c),
    .cnt_a(cnt_a), .cnt_b(cnt_b), .cnt_c(cnt_c), .clr(clr), .rpt_valid(rpt_valid),
    .rpt_ready(rpt_ready), .rpt_data(rpt_data), .rpt_ovf(rpt_ovf)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  bit                m_valid;
  logic [W-1:0]      m_data;
  logic [2:0]        m_err;
  int                m_cnt [3];
  int                m_ts;
  bit                m_ovf;
  logic [3+TS_W-1:0] m_q [$];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] majority(input logic [W-1:0] a, b, c);
    logic [W-1:0] r;
    for (int j = 0; j < W; j++) r[j] = (int'(a[j]) + int'(b[j]) + int'(c[j])) >= 2;
    return r;
  endfunction

  task automatic model_update(input logic [W-1:0] a, b, c, input bit v, ready, cl, r);
    logic [W-1:0] voted;
    logic [2:0]   mask;
    int           had;
    bit           popped, dropped;
    if (r) begin
      m_valid = 0; m_data = '0; m_err = 3'b000; m_ts = 0; m_ovf = 0;
      for (int i = 0; i < 3; i++) m_cnt[i] = 0;
      m_q.delete();
      return;
    end
    voted = majority(a, b, c);
    mask  = v ? {a != voted, b != voted, c != voted} : 3'b000;
    m_valid = v;
    if (v) m_data = voted;
    m_err = mask;
    for (int i = 0; i < 3; i++) begin
      if (cl) m_cnt[i] = 0;
      else if (mask[2-i] && m_cnt[i] < CMAX) m_cnt[i]++;
    end
    dropped = 0;
    if (FIFO_EN) begin
      had    = m_q.size();
      popped = (had > 0) && ready;
      if (popped) void'(m_q.pop_front());
      if (mask != 0) begin
        if (had < DEPTH || popped) m_q.push_back({mask, m_ts[TS_W-1:0]});
        else dropped = 1;
      end
      if (cl) m_ovf = 0;
      else if (dropped) m_ovf = 1;
      m_ts = (m_ts + 1) % (1 << TS_W);
    end
  endtask

  task automatic check_all();
    check_eq("out_valid", out_valid, m_valid);
    check_eq("out_data", out_data, m_data);
    check_eq("err_a", err_a, m_err[2]);
    check_eq("err_b", err_b, m_err[1]);
    check_eq("err_c", err_c, m_err[0]);
    check_eq("cnt_a", cnt_a, m_cnt[0]);
    check_eq("cnt_b", cnt_b, m_cnt[1]);
    check_eq("cnt_c", cnt_c, m_cnt[2]);
    check_eq("rpt_valid", rpt_valid, m_q.size() > 0);
    check_eq("rpt_data", rpt_data, m_q.size() > 0 ? m_q[0] : '0);
    check_eq("rpt_ovf", rpt_ovf, m_ovf);
  endtask

  task automatic step(input logic [W-1:0] a, b, c, input bit v, ready, cl, r);
    in_a = a; in_b = b; in_c = c; in_valid = v; rpt_ready = ready; clr = cl; rst = r;
    @(posedge clk);
    model_update(a, b, c, v, ready, cl, r);
    #1;
    check_all();
  endtask

  initial begin
    logic [W-1:0] a, b, c;
    int mode;
    rst = 1; in_valid = 0; clr = 0; rpt_ready = 0; in_a = '0; in_b = '0; in_c = '0;
    step(8'h00, 8'h00, 8'h00, 0, 0, 0, 1);
    step(8'h00, 8'h00, 8'h00, 0, 0, 0, 1);

    for (int i = 0; i < 10; i++) step(8'hA5, 8'hA5, 8'hA5, 1, 0, 0, 0);
    step(8'hA5, 8'hA5, 8'h24, 1, 0, 0, 0);
    check_eq("s2_cnt_c", cnt_c, 1);
    step(8'h01, 8'h02, 8'h00, 1, 1, 0, 0);
    check_eq("s3_vote", out_data, 8'h00);
    step(8'h00, 8'h00, 8'h00, 0, 1, 0, 0);
    step(8'h00, 8'h00, 8'h00, 0, 1, 0, 0);

    for (int i = 0; i < 6; i++) step(8'h3C, 8'h3C, 8'hC3, 1, 0, 0, 0);
    check_eq("s4_ovf", rpt_ovf, FIFO_EN);
    step(8'h3C, 8'h81, 8'h3C, 1, 1, 0, 0);
    for (int i = 0; i < 6; i++) step(8'h00, 8'h00, 8'h00, 1, 1, 0, 0);

    for (int i = 0; i < 20; i++) step(8'hFF, 8'h00, 8'h00, 1, 1, 0, 0);
    check_eq("s5_sat", cnt_a, CMAX);
    for (int i = 0; i < 5; i++) step(8'h00, 8'h00, 8'h00, 0, 1, 0, 0);
    step(8'h10, 8'h00, 8'h00, 1, 0, 1, 0);
    check_eq("s5_clr", cnt_a, 0);
    check_eq("s5_clr_push", rpt_valid, FIFO_EN);
    step(8'h00, 8'h00, 8'h00, 0, 1, 0, 0);

    for (int i = 0; i < 3; i++) step(8'h00, 8'h00, 8'h77, 1, 0, 0, 0);
    step(8'h00, 8'h00, 8'h00, 1, 0, 0, 1);
    check_eq("s6_rst_valid", rpt_valid, 0);
    check_eq("s6_rst_out", out_valid, 0);

    for (int i = 0; i < 3000; i++) begin
      a = W'($urandom); b = a; c = a;
      mode = $urandom_range(0, 3);
      if (mode == 1) begin
        case ($urandom_range(0, 2))
          0: a = a ^ W'($urandom);
          1: b = b ^ W'($urandom);
          default: c = c ^ W'($urandom);
        endcase
      end else if (mode == 2) begin
        b = W'($urandom); c = W'($urandom);
      end
      step(a, b, c, $urandom_range(0, 9) < 8, $urandom_range(0, 1) == 1,
           $urandom_range(0, 19) == 0, $urandom_range(0, 99) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
